// File: rtl/mem_access_pkg.sv
// Shared definitions for the memory access stage: default widths and the
// response-state encoding mirrored from the upstream read/write control FSM.
package mem_access_pkg;

    localparam int unsigned DEF_DATA_W = 8;
    localparam int unsigned DEF_DEPTH  = 16;
    localparam int unsigned DEF_ADDR_W = 5;
    localparam int unsigned DEF_CNT_W  = 8;

    typedef enum logic [1:0] {
        RSP_IDLE = 2'b00,
        RSP_ERR  = 2'b01,
        RSP_RD   = 2'b10,
        RSP_WR   = 2'b11
    } rsp_state_t;

endpackage

// File: rtl/mem_array_rf.sv
// Register-file word array with one synchronous write port and one
// combinational read port; parity column present only with MEM_ACCESS_PARITY_EN.
module mem_array_rf #(
    parameter int unsigned DATA_W = mem_access_pkg::DEF_DATA_W,
    parameter int unsigned DEPTH  = mem_access_pkg::DEF_DEPTH,
    parameter int unsigned ADDR_W = mem_access_pkg::DEF_ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr,
`ifdef MEM_ACCESS_PARITY_EN
    output logic              rpar_raw,
`endif
    output logic [DATA_W-1:0] rdata_raw
);

    logic [DATA_W-1:0] mem [DEPTH];
`ifdef MEM_ACCESS_PARITY_EN
    logic              par [DEPTH];
`endif

    // Decoded per-word enables keep index widths exact for non-power-of-two DEPTH.
    always_ff @(posedge clk) begin
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (rst) begin
                mem[i] <= '0;
`ifdef MEM_ACCESS_PARITY_EN
                par[i] <= 1'b0;
`endif
            end else if (we && waddr == ADDR_W'(i)) begin
                mem[i] <= wdata;
`ifdef MEM_ACCESS_PARITY_EN
                par[i] <= ^wdata;
`endif
            end
        end
    end

    always_comb begin
        rdata_raw = '0;
`ifdef MEM_ACCESS_PARITY_EN
        rpar_raw  = 1'b0;
`endif
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (raddr == ADDR_W'(i)) begin
                rdata_raw = mem[i];
`ifdef MEM_ACCESS_PARITY_EN
                rpar_raw  = par[i];
`endif
            end
        end
    end

endmodule

// File: rtl/mem_access_unit.sv
// Single-word access stage behind the read/write control FSM: request decode,
// response FSM, registered read data and saturating access counter. Parity via MEM_ACCESS_PARITY_EN.
module mem_access_unit #(
    parameter int unsigned DATA_W = mem_access_pkg::DEF_DATA_W,
    parameter int unsigned DEPTH  = mem_access_pkg::DEF_DEPTH,
    parameter int unsigned ADDR_W = mem_access_pkg::DEF_ADDR_W,
    parameter int unsigned CNT_W  = mem_access_pkg::DEF_CNT_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              valid,
    input  logic              rw,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata,
    output logic              rdata_valid,
    output logic              wr_ack,
    output logic              addr_err,
    output logic              par_err,
    output logic [CNT_W-1:0]  op_count
);

    import mem_access_pkg::*;

    localparam int unsigned DEPTH_I = DEPTH;
    localparam logic [ADDR_W:0] DEPTH_L = DEPTH_I[ADDR_W:0];

    rsp_state_t        state, state_next;
    logic              in_range, wr_en, rd_en;
    logic [DATA_W-1:0] rdata_raw;

    assign in_range = {1'b0, addr} < DEPTH_L;
    assign wr_en    = valid &&  rw && in_range;
    assign rd_en    = valid && !rw && in_range;

`ifdef MEM_ACCESS_PARITY_EN
    logic rpar_raw;
    logic par_q;
`endif

    mem_array_rf #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_array (
        .clk       (clk),
        .rst       (rst),
        .we        (wr_en),
        .waddr     (addr),
        .wdata     (wdata),
        .raddr     (addr),
`ifdef MEM_ACCESS_PARITY_EN
        .rpar_raw  (rpar_raw),
`endif
        .rdata_raw (rdata_raw)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= RSP_IDLE;
            rdata    <= '0;
            op_count <= '0;
        end else begin
            state <= state_next;
            if (rd_en) begin
                rdata <= rdata_raw;
            end
            if ((wr_en || rd_en) && op_count != '1) begin
                op_count <= op_count + 1'b1;
            end
        end
    end

    always_comb begin
        state_next  = RSP_IDLE;
        rdata_valid = 1'b0;
        wr_ack      = 1'b0;
        addr_err    = 1'b0;
        if (valid) begin
            if (!in_range) begin
                state_next = RSP_ERR;
            end else if (rw) begin
                state_next = RSP_WR;
            end else begin
                state_next = RSP_RD;
            end
        end
        case (state)
            RSP_RD:  rdata_valid = 1'b1;
            RSP_WR:  wr_ack      = 1'b1;
            RSP_ERR: addr_err    = 1'b1;
            default: ;
        endcase
    end

`ifdef MEM_ACCESS_PARITY_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            par_q <= 1'b0;
        end else begin
            par_q <= rd_en && ((^rdata_raw) != rpar_raw);
        end
    end
    assign par_err = (state == RSP_RD) && par_q;
`else
    assign par_err = 1'b0;
`endif

endmodule
